// File: rtl/mac_pkg.sv
// Shared definitions for the tiled MAC array: operation encodings, FSM state
// enumeration and the column-sum width helper.
package mac_pkg;

  localparam logic [1:0] OP_UMUL = 2'b00;
  localparam logic [1:0] OP_SMUL = 2'b01;
  localparam logic [1:0] OP_XNOR = 2'b10;
  localparam logic [1:0] OP_AND  = 2'b11;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, OUT} state_e;

  // Width of one lane's column sum: a full product plus growth over K rows plus sign.
  function automatic int unsigned colsum_w(input int unsigned dw, input int unsigned kmax);
    return 2 * dw + $clog2(kmax) + 1;
  endfunction

endpackage

// File: rtl/mac_lane.sv
// One MAC lane: weight store, registered column-sum stage and accumulator.
// Ports: clk/rst_n (sync active-low), clr (zero accumulator), load_w (latch
// weight_in), beat (accepted ifmap column), en (lane enable), weight_in
// (K_MAX*K_MAX elements), ifmap_in (K_MAX rows), col/ks/op (current column,
// kernel size, operation), psum (accumulator).
// Build option: MAC_ARRAY_SATURATE_EN makes the accumulator saturate instead of wrap.
module mac_lane
  import mac_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 1,
  parameter int unsigned K_MAX      = 5,
  parameter int unsigned ACC_W      = 10,
  parameter int unsigned COL_W      = 3,
  parameter int unsigned KS_W       = 3
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                clr,
  input  logic                                load_w,
  input  logic                                beat,
  input  logic                                en,
  input  logic [DATA_WIDTH*K_MAX*K_MAX-1:0]   weight_in,
  input  logic [DATA_WIDTH*K_MAX-1:0]         ifmap_in,
  input  logic [COL_W-1:0]                    col,
  input  logic [KS_W-1:0]                     ks,
  input  logic [1:0]                          op,
  output logic [ACC_W-1:0]                    psum
);

  localparam int unsigned CW = colsum_w(DATA_WIDTH, K_MAX);
  localparam int unsigned PW = 2 * DATA_WIDTH + 2;
  localparam int unsigned SW = ACC_W + CW + 1;

  logic [DATA_WIDTH*K_MAX*K_MAX-1:0] w_q, w_d;
  logic signed [CW-1:0]              colsum_q, colsum_d;
  logic                              colvld_q, colvld_d;
  logic [ACC_W-1:0]                  acc_q, acc_d;

  // Stage 1: sum of f(ifmap[r], w[r][col]) over the active rows.
  always_comb begin : col_sum
    logic [DATA_WIDTH-1:0]   a, b;
    logic signed [DATA_WIDTH:0] a_ext, b_ext;
    logic signed [PW-1:0]    prod;
    logic signed [CW-1:0]    term;
    int unsigned             widx;
    colsum_d = '0;
    a = '0; b = '0; a_ext = '0; b_ext = '0; prod = '0; term = '0; widx = 0;
    for (int unsigned r = 0; r < K_MAX; r++) begin
      widx  = (r * K_MAX + 32'(col)) * DATA_WIDTH;
      a     = ifmap_in[r*DATA_WIDTH +: DATA_WIDTH];
      b     = w_q[widx +: DATA_WIDTH];
      a_ext = (op == OP_SMUL) ? {a[DATA_WIDTH-1], a} : {1'b0, a};
      b_ext = (op == OP_SMUL) ? {b[DATA_WIDTH-1], b} : {1'b0, b};
      prod  = a_ext * b_ext;
      case (op)
        OP_XNOR: term = CW'($countones(~(a ^ b)));
        OP_AND:  term = CW'($countones(a & b));
        default: term = CW'(prod);
      endcase
      if (r < 32'(ks)) colsum_d = colsum_d + term;
    end
  end

  // Weight latch and stage-1 valid.
  always_comb begin
    w_d      = load_w ? weight_in : w_q;
    colvld_d = beat;
  end

`ifdef MAC_ARRAY_SATURATE_EN
  localparam logic signed [SW-1:0] SMAX = {{(SW-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [SW-1:0] SMIN = ~SMAX;
  localparam logic signed [SW-1:0] UMAX = {{(SW-ACC_W){1'b0}}, {ACC_W{1'b1}}};
`endif

  // Stage 2: accumulate the registered column sum; op 01 treats the accumulator as signed.
  always_comb begin : acc_upd
    logic signed [SW-1:0] acc_ext, cs_ext, sum;
    acc_ext = (op == OP_SMUL) ? SW'($signed(acc_q)) : SW'(acc_q);
    cs_ext  = SW'(colsum_q);
    sum     = acc_ext + cs_ext;
    acc_d   = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (colvld_q && en) begin
`ifdef MAC_ARRAY_SATURATE_EN
      if (op == OP_SMUL) begin
        if (sum > SMAX)      acc_d = ACC_W'(SMAX);
        else if (sum < SMIN) acc_d = ACC_W'(SMIN);
        else                 acc_d = ACC_W'(sum);
      end else if (sum > UMAX) begin
        acc_d = ACC_W'(UMAX);
      end else begin
        acc_d = ACC_W'(sum);
      end
`else
      acc_d = ACC_W'(sum);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_q      <= '0;
      colsum_q <= '0;
      colvld_q <= 1'b0;
      acc_q    <= '0;
    end else begin
      w_q      <= w_d;
      colsum_q <= colsum_d;
      colvld_q <= colvld_d;
      acc_q    <= acc_d;
    end
  end

  assign psum = acc_q;

endmodule

// File: rtl/mac_array_tiled.sv
// Tiled MAC array: MAC_NUM lanes each accumulating one output pixel of a K x K
// convolution over num_ch channels. Holds the tile FSM, column/channel counters
// and valid/ready handshakes.
// Ports: clk, rst_n (sync active-low), start/kernel_size/num_ch/operation/enable
// (tile config, sampled on start in IDLE), load_weight/weight_in (weight preload),
// in_valid/in_ready/ifmap_in (column beats), out_valid/out_ready/psum_out (results),
// busy, err_wload (sticky rejected weight load).
// Build option: MAC_ARRAY_SATURATE_EN selects saturating accumulators.
module mac_array_tiled
  import mac_pkg::*;
#(
  parameter int unsigned MAC_NUM    = 256,
  parameter int unsigned DATA_WIDTH = 1,
  parameter int unsigned K_MAX      = 5,
  parameter int unsigned CH_MAX     = 16,
  parameter int unsigned ACC_W      = 10
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      start,
  input  logic [$clog2(K_MAX+1)-1:0]                kernel_size,
  input  logic [$clog2(CH_MAX+1)-1:0]               num_ch,
  input  logic [1:0]                                operation,
  input  logic [MAC_NUM-1:0]                        enable,
  input  logic                                      load_weight,
  input  logic [DATA_WIDTH*K_MAX*K_MAX*MAC_NUM-1:0] weight_in,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [DATA_WIDTH*K_MAX*MAC_NUM-1:0]       ifmap_in,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [ACC_W*MAC_NUM-1:0]                  psum_out,
  output logic                                      busy,
  output logic                                      err_wload
);

  localparam int unsigned KS_W  = $clog2(K_MAX + 1);
  localparam int unsigned CH_W  = $clog2(CH_MAX + 1);
  localparam int unsigned COL_W = (K_MAX > 1) ? $clog2(K_MAX) : 1;
  localparam int unsigned CHC_W = (CH_MAX > 1) ? $clog2(CH_MAX) : 1;
  localparam int unsigned LW_W  = DATA_WIDTH * K_MAX * K_MAX;
  localparam int unsigned LI_W  = DATA_WIDTH * K_MAX;

  state_e             state_q, state_d;
  logic [COL_W-1:0]   col_cnt_q, col_cnt_d;
  logic [CHC_W-1:0]   ch_cnt_q, ch_cnt_d;
  logic [KS_W-1:0]    ks_q, ks_d;
  logic [CH_W-1:0]    nch_q, nch_d;
  logic [1:0]         op_q, op_d;
  logic [MAC_NUM-1:0] en_q, en_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;
  logic               err_wload_q, err_wload_d;

  logic               beat_c, last_col_c, last_ch_c, wload_ok_c, clr_c;
  logic [KS_W-1:0]    ks_clamp_c;
  logic [CH_W-1:0]    nch_clamp_c;

  assign beat_c     = (state_q == RUN) && in_valid;
  assign last_col_c = (KS_W'(col_cnt_q) == ks_q - KS_W'(1));
  assign last_ch_c  = (CH_W'(ch_cnt_q) == nch_q - CH_W'(1));
  // Weights may change only between columns, never under an accepted beat.
  assign wload_ok_c = load_weight &&
                      ((state_q == IDLE) ||
                       ((state_q == RUN) && (col_cnt_q == '0) && !beat_c));

  assign ks_clamp_c  = (kernel_size == '0) ? KS_W'(1) :
                       (kernel_size > KS_W'(K_MAX)) ? KS_W'(K_MAX) : kernel_size;
  assign nch_clamp_c = (num_ch == '0) ? CH_W'(1) :
                       (num_ch > CH_W'(CH_MAX)) ? CH_W'(CH_MAX) : num_ch;

  // Tile sequencing; once started the array loops RUN/FLUSH/OUT until reset.
  always_comb begin
    state_d     = state_q;
    col_cnt_d   = col_cnt_q;
    ch_cnt_d    = ch_cnt_q;
    ks_d        = ks_q;
    nch_d       = nch_q;
    op_d        = op_q;
    en_d        = en_q;
    clr_c       = 1'b0;
    err_wload_d = err_wload_q | (load_weight & ~wload_ok_c);
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RUN;
          ks_d      = ks_clamp_c;
          nch_d     = nch_clamp_c;
          op_d      = operation;
          en_d      = enable;
          clr_c     = 1'b1;
          col_cnt_d = '0;
          ch_cnt_d  = '0;
        end
      end
      RUN: begin
        if (beat_c) begin
          if (last_col_c) begin
            col_cnt_d = '0;
            if (last_ch_c) begin
              ch_cnt_d = '0;
              state_d  = FLUSH;
            end else begin
              ch_cnt_d = ch_cnt_q + CHC_W'(1);
            end
          end else begin
            col_cnt_d = col_cnt_q + COL_W'(1);
          end
        end
      end
      FLUSH: state_d = OUT;
      OUT: begin
        if (out_ready) begin
          state_d   = RUN;
          clr_c     = 1'b1;
          col_cnt_d = '0;
          ch_cnt_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == RUN);
    out_valid_d = (state_d == OUT);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      col_cnt_q   <= '0;
      ch_cnt_q    <= '0;
      ks_q        <= '0;
      nch_q       <= '0;
      op_q        <= '0;
      en_q        <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      err_wload_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_cnt_q   <= col_cnt_d;
      ch_cnt_q    <= ch_cnt_d;
      ks_q        <= ks_d;
      nch_q       <= nch_d;
      op_q        <= op_d;
      en_q        <= en_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      err_wload_q <= err_wload_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign err_wload = err_wload_q;

  for (genvar l = 0; l < MAC_NUM; l++) begin : g_lane
    mac_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .K_MAX      (K_MAX),
      .ACC_W      (ACC_W),
      .COL_W      (COL_W),
      .KS_W       (KS_W)
    ) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr_c),
      .load_w    (wload_ok_c),
      .beat      (beat_c),
      .en        (en_q[l]),
      .weight_in (weight_in[l*LW_W +: LW_W]),
      .ifmap_in  (ifmap_in[l*LI_W +: LI_W]),
      .col       (col_cnt_q),
      .ks        (ks_q),
      .op        (op_q),
      .psum      (psum_out[l*ACC_W +: ACC_W])
    );
  end

endmodule

// File: doc/mac_array_tiled.md
Name: mac_array_tiled

Overview:
- Parametrised successor of the 1-bit MAC array: MAC_NUM independent lanes, each computing one output pixel of a K×K convolution tile.
- Multi-bit data. Runtime kernel size. Selectable op. Per-lane accumulation over num_ch input channels.
- Valid/ready handshakes on ifmap input and psum output.
- Sits between the ifmap FIFO / weight preload and the psum writeback buffer, sequenced by the control unit.

Parameters:
- MAC_NUM, 256, number of lanes
- DATA_WIDTH, 1, bits per ifmap/weight element
- K_MAX, 5, max kernel dimension
- CH_MAX, 16, max channels accumulated per tile
- ACC_W, 10, per-lane accumulator/psum width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- start  in  1  pulse, begin tile sequence (IDLE only)
- kernel_size  in  $clog2(K_MAX+1)  sampled on start
- num_ch  in  $clog2(CH_MAX+1)  sampled on start
- operation  in  2  sampled on start: 00 umul, 01 smul, 10 xnor-popcount, 11 and-popcount
- enable  in  MAC_NUM  per-lane enable, sampled on start
- load_weight  in  1  latch weight_in into all lanes
- weight_in  in  DATA_WIDTH*K_MAX*K_MAX*MAC_NUM  element (l,r,c) at bit ((l*K_MAX+r)*K_MAX+c)*DATA_WIDTH
- in_valid  in  1  ifmap column beat valid
- in_ready  out  1  column beat accepted when in_valid&&in_ready
- ifmap_in  in  DATA_WIDTH*K_MAX*MAC_NUM  element (l,r) at bit (l*K_MAX+r)*DATA_WIDTH
- out_valid  out  1  psum_out valid
- out_ready  in  1  consumer accepts
- psum_out  out  ACC_W*MAC_NUM  lane l at [l*ACC_W +: ACC_W]
- busy  out  1  state != IDLE
- err_wload  out  1  sticky: load_weight rejected

Behaviour:
- Reset: all outputs 0; state IDLE; counters, accumulators, weights 0.
- Start clamps: kernel_size 0→1, >K_MAX→K_MAX. num_ch 0→1, >CH_MAX→CH_MAX. start outside IDLE is ignored.
- States:
  - IDLE: start → RUN; clear col_cnt, ch_cnt, accumulators.
  - RUN: in_ready=1. Each accepted beat supplies column col_cnt of the current channel.
  - FLUSH: 1 cycle, final column sum enters accumulator.
  - OUT: out_valid=1.
- Column processing, stage 1 (registered): per lane, column sum = Σ over rows r<ks of f(ifmap[r], w[r][col_cnt]).
  - f per op: unsigned product; signed product; popcount(~(a^b)); popcount(a&b).
  - Rows ≥ks and columns ≥ks contribute nothing.
  - Column-sum width 2*DATA_WIDTH+$clog2(K_MAX)+1, signed in op 01.
- Stage 2: accumulator += column sum; disabled lanes hold 0.
- Counters:
  - col_cnt wraps at ks−1 → ch_cnt++.
  - Last column of last channel accepted → in_ready=0 next cycle, RUN→FLUSH→OUT.
  - out_valid rises 2 cycles after the final accepted beat.
- OUT: psum_out and out_valid held stable while out_ready=0. On handshake: clear accumulators and counters, → RUN (next tile, same config), out_valid=0 next cycle.
- IDLE return: start is not required per tile. Reset is the only path back to IDLE.
- load_weight:
  - Accepted in IDLE, or in RUN with col_cnt==0 and no beat accepted that cycle. Weights are updated for the next accepted beat.
  - Otherwise ignored and err_wload set; err_wload clears only on reset.
- Simultaneous in_valid beat and load_weight at col_cnt==0: beat uses old weights; load rejected, err_wload=1.
- Overflow: accumulator wraps modulo 2^ACC_W (signed two's complement in op 01).
- Reset mid-operation: next edge returns every register to reset values. No partial psum is emitted.

Optional Feature:
- Macro MAC_ARRAY_SATURATE_EN.
- Defined: accumulator saturates (unsigned ops clamp to 2^ACC_W−1; op 01 clamps to [−2^(ACC_W−1), 2^(ACC_W−1)−1]).
- Undefined: wrap as above.

Decomposition:
- Package mac_pkg holds:
  - op encodings OP_UMUL/OP_SMUL/OP_XNOR/OP_AND;
  - state enum {IDLE,RUN,FLUSH,OUT};
  - colsum-width function.
- Sub-module mac_lane: one lane's weight store, column-sum stage, accumulator.
- The top holds the FSM, counters and handshakes, plus a generate loop of mac_lane.

Test Plan (MAC_NUM=4, K_MAX=5, CH_MAX=16, ACC_W=10):
- DATA_WIDTH=1, op=10, ks=3, ch=1, weights/ifmaps all 1 → 3 beats, psum=9 per lane, out_valid exactly 2 cycles after 3rd beat.
- op=11, ks=5, ch=4, all ones, enable=4'b0101 → lanes 0,2=100, lanes 1,3=0; in_ready low from cycle after beat 20.
- Backpressure: hold out_ready=0 5 cycles → psum_out/out_valid stable, in_ready=0. Then handshake → next tile accumulates from 0.
- load_weight at col_cnt=2 → ignored, err_wload=1. Reload at ch boundary → new weights used for next channel's column 0.
- Assert rst_n=0 mid-RUN (ch_cnt=2) → next cycle busy=0, in_ready=0, out_valid=0, psum_out=0.
- DATA_WIDTH=4, op=00, ks=5, ch=1, all 15 → without macro psum=505 (5625 mod 1024); with MAC_ARRAY_SATURATE_EN psum=1023.
